// File: rtl/fp_addsub_iter_pkg.sv
// Shared types, default format widths and constant helpers for the iterative FP adder.
package fp_pkg;

  localparam int unsigned DEF_EXP_W = 8;
  localparam int unsigned DEF_MAN_W = 7;
  localparam int unsigned W         = 1 + DEF_EXP_W + DEF_MAN_W;
  localparam int unsigned XW        = DEF_MAN_W + 5;
  localparam int unsigned EXP_MAX   = (1 << DEF_EXP_W) - 1;
  localparam int unsigned BIAS      = (1 << (DEF_EXP_W - 1)) - 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ALIGN = 3'd1,
    S_ADD   = 3'd2,
    S_NORM  = 3'd3,
    S_ROUND = 3'd4,
    S_DONE  = 3'd5
  } state_e;

  // Canonical quiet NaN {0, all-ones exponent, 1, zeros}, right-aligned in 64 bits.
  function automatic logic [63:0] qnan(input int unsigned exp_w, input int unsigned man_w);
    logic [63:0] r;
    r = '0;
    for (int unsigned i = 0; i < exp_w; i++) r[man_w + i] = 1'b1;
    r[man_w - 1] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/fp_addsub_iter_if.sv
// Operand/result handshake bundle for fp_addsub_iter.
interface fp_addsub_iter_if #(
  parameter int unsigned EXP_W = fp_pkg::DEF_EXP_W,
  parameter int unsigned MAN_W = fp_pkg::DEF_MAN_W
);
  localparam int unsigned OP_W = 1 + EXP_W + MAN_W;

  logic            in_valid;
  logic            in_ready;
  logic [OP_W-1:0] a;
  logic [OP_W-1:0] b;
  logic            sub;
  logic            out_valid;
  logic            out_ready;
  logic [OP_W-1:0] sum;
  logic            ovf;
  logic            unf;

  modport master (
    output in_valid, a, b, sub, out_ready,
    input  in_ready, out_valid, sum, ovf, unf
  );

  modport slave (
    input  in_valid, a, b, sub, out_ready,
    output in_ready, out_valid, sum, ovf, unf
  );
endinterface

// File: rtl/fp_addsub_iter_unpack.sv
// Splits an operand into fields and class flags; exp==0 inputs are flushed to signed zero.
module fp_unpack #(
  parameter int unsigned EXP_W = 8,
  parameter int unsigned MAN_W = 7
) (
  input  logic [EXP_W+MAN_W:0] op_i,
  output logic                 sign_o,
  output logic [EXP_W-1:0]     exp_o,
  output logic [MAN_W:0]       mant_o,
  output logic                 is_zero_o,
  output logic                 is_inf_o,
  output logic                 is_nan_o
);
  logic exp_ones;
  logic man_nz;

  assign sign_o    = op_i[EXP_W+MAN_W];
  assign exp_o     = op_i[EXP_W+MAN_W-1:MAN_W];
  assign exp_ones  = &exp_o;
  assign man_nz    = |op_i[MAN_W-1:0];
  assign is_zero_o = (exp_o == '0);
  assign is_inf_o  = exp_ones && !man_nz;
  assign is_nan_o  = exp_ones && man_nz;
  assign mant_o    = is_zero_o ? '0 : {1'b1, op_i[MAN_W-1:0]};
endmodule

// File: rtl/fp_addsub_iter.sv
// Iterative RNE floating-point add/subtract: one alignment or normalisation shift per cycle.
module fp_addsub_iter
  import fp_pkg::*;
#(
  parameter int unsigned EXP_W = DEF_EXP_W,
  parameter int unsigned MAN_W = DEF_MAN_W
) (
  input logic           clock,
  input logic           nreset,
  fp_addsub_iter_if.slave bus
);
  localparam int unsigned OP_W   = 1 + EXP_W + MAN_W;
  localparam int unsigned EXT_W  = MAN_W + 5;
  localparam int unsigned SH_MAX = MAN_W + 3;
  localparam int unsigned CNT_W  = $clog2(SH_MAX + 1);
  localparam int unsigned EMAX   = (1 << EXP_W) - 1;
  localparam logic [OP_W-1:0] QNAN = OP_W'(qnan(EXP_W, MAN_W));

  state_e           state_q, state_d;
  logic [EXT_W-1:0] big_q, big_d, sml_q, sml_d;
  logic             sgn_big_q, sgn_big_d, sgn_sml_q, sgn_sml_d;
  logic [EXP_W-1:0] exp_q, exp_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [OP_W-1:0]  sum_q, sum_d;
  logic             ovf_q, ovf_d, unf_q, unf_d, oval_q, oval_d;

  logic [OP_W-1:0]  b_eff;
  logic             a_s, b_s, a_z, b_z, a_i, b_i, a_n, b_n;
  logic [EXP_W-1:0] a_e, b_e;
  logic [MAN_W:0]   a_m, b_m;

  // Subtraction is folded into b's sign before classification.
  assign b_eff = {bus.b[OP_W-1] ^ bus.sub, bus.b[OP_W-2:0]};

  fp_unpack #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_unpack_a (
    .op_i(bus.a), .sign_o(a_s), .exp_o(a_e), .mant_o(a_m),
    .is_zero_o(a_z), .is_inf_o(a_i), .is_nan_o(a_n)
  );

  fp_unpack #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_unpack_b (
    .op_i(b_eff), .sign_o(b_s), .exp_o(b_e), .mant_o(b_m),
    .is_zero_o(b_z), .is_inf_o(b_i), .is_nan_o(b_n)
  );

  logic             a_ge;
  logic [EXP_W-1:0] diff, exp_inc, exp_dec;
  logic [EXT_W-1:0] add_res;
  logic             add_sgn;
  logic             inc;
  logic [MAN_W:0]   rnd;

  always_comb begin
    a_ge    = (a_e >= b_e);
    diff    = a_ge ? (a_e - b_e) : (b_e - a_e);
    exp_inc = exp_q + EXP_W'(1);
    exp_dec = exp_q - EXP_W'(1);
    add_res = big_q + sml_q;
    add_sgn = sgn_big_q;
    if (sgn_big_q != sgn_sml_q) begin
      if (big_q >= sml_q) begin
        add_res = big_q - sml_q;
      end else begin
        add_res = sml_q - big_q;
        add_sgn = sgn_sml_q;
      end
    end
    inc = big_q[2] && (big_q[1] || big_q[0] || big_q[3]);
    rnd = {1'b0, big_q[MAN_W+2:3]} + {{MAN_W{1'b0}}, inc};
  end

  always_comb begin
    state_d   = state_q;
    big_d     = big_q;
    sml_d     = sml_q;
    sgn_big_d = sgn_big_q;
    sgn_sml_d = sgn_sml_q;
    exp_d     = exp_q;
    cnt_d     = cnt_q;
    sum_d     = sum_q;
    ovf_d     = ovf_q;
    unf_d     = unf_q;
    oval_d    = oval_q;

    case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          ovf_d   = 1'b0;
          unf_d   = 1'b0;
          state_d = S_DONE;
          if (a_n || b_n || (a_i && b_i && (a_s != b_s))) sum_d = QNAN;
          else if (a_i)          sum_d = bus.a;
          else if (b_i)          sum_d = b_eff;
          else if (a_z && b_z)   sum_d = {a_s & b_s, {(OP_W-1){1'b0}}};
          else if (a_z)          sum_d = b_eff;
          else if (b_z)          sum_d = bus.a;
          else begin
            state_d   = S_ALIGN;
            exp_d     = a_ge ? a_e : b_e;
            big_d     = a_ge ? {1'b0, a_m, 3'b000} : {1'b0, b_m, 3'b000};
            sml_d     = a_ge ? {1'b0, b_m, 3'b000} : {1'b0, a_m, 3'b000};
            sgn_big_d = a_ge ? a_s : b_s;
            sgn_sml_d = a_ge ? b_s : a_s;
            cnt_d     = (diff > EXP_W'(SH_MAX)) ? CNT_W'(SH_MAX) : CNT_W'(diff);
          end
        end
      end

      S_ALIGN: begin
        if (cnt_q == '0) begin
          state_d = S_ADD;
        end else begin
          sml_d = {1'b0, sml_q[EXT_W-1:2], sml_q[1] | sml_q[0]};
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      S_ADD: begin
        if (add_res == '0) begin
          sum_d   = '0;
          oval_d  = 1'b1;
          state_d = S_DONE;
        end else begin
          big_d     = add_res;
          sgn_big_d = add_sgn;
          state_d   = S_NORM;
        end
      end

      S_NORM: begin
        if (big_q[EXT_W-1]) begin
          big_d = {1'b0, big_q[EXT_W-1:2], big_q[1] | big_q[0]};
          if (exp_q == EXP_W'(EMAX - 1)) begin
            sum_d   = {sgn_big_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            ovf_d   = 1'b1;
            oval_d  = 1'b1;
            state_d = S_DONE;
          end else begin
            exp_d   = exp_inc;
            state_d = S_ROUND;
          end
        end else if (big_q[EXT_W-2]) begin
          state_d = S_ROUND;
        end else if (exp_q == EXP_W'(1)) begin
          sum_d   = {sgn_big_q, {(OP_W-1){1'b0}}};
          unf_d   = 1'b1;
          oval_d  = 1'b1;
          state_d = S_DONE;
        end else begin
          big_d = {big_q[EXT_W-2:0], 1'b0};
          exp_d = exp_dec;
        end
      end

      S_ROUND: begin
        oval_d  = 1'b1;
        state_d = S_DONE;
        if (!rnd[MAN_W]) begin
          sum_d = {sgn_big_q, exp_q, rnd[MAN_W-1:0]};
        end else if (exp_q == EXP_W'(EMAX - 1)) begin
          sum_d = {sgn_big_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
          ovf_d = 1'b1;
        end else begin
          sum_d = {sgn_big_q, exp_inc, {MAN_W{1'b0}}};
        end
      end

      // Specials enter DONE straight from IDLE with valid still low; it is raised here a cycle later.
      S_DONE: begin
        oval_d = 1'b1;
        if (oval_q && bus.out_ready) begin
          oval_d  = 1'b0;
          state_d = S_IDLE;
        end
      end

      default: begin
        oval_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!nreset) begin
      state_q   <= S_IDLE;
      big_q     <= '0;
      sml_q     <= '0;
      sgn_big_q <= 1'b0;
      sgn_sml_q <= 1'b0;
      exp_q     <= '0;
      cnt_q     <= '0;
      sum_q     <= '0;
      ovf_q     <= 1'b0;
      unf_q     <= 1'b0;
      oval_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      big_q     <= big_d;
      sml_q     <= sml_d;
      sgn_big_q <= sgn_big_d;
      sgn_sml_q <= sgn_sml_d;
      exp_q     <= exp_d;
      cnt_q     <= cnt_d;
      sum_q     <= sum_d;
      ovf_q     <= ovf_d;
      unf_q     <= unf_d;
      oval_q    <= oval_d;
    end
  end

  assign bus.in_ready  = (state_q == S_IDLE);
  assign bus.out_valid = oval_q;
  assign bus.sum       = sum_q;
  assign bus.ovf       = ovf_q;
  assign bus.unf       = unf_q;
endmodule

// File: tb/tb_fp_addsub_iter.sv
// Directed bf16 vectors for fp_addsub_iter: results, flags, latency, backpressure and reset.
module tb_fp_addsub_iter;
  import fp_pkg::*;

  localparam logic [W-1:0] ONE  = {1'b0, DEF_EXP_W'(BIAS), DEF_MAN_W'(0)};
  localparam logic [W-1:0] PINF = {1'b0, DEF_EXP_W'(EXP_MAX), DEF_MAN_W'(0)};

  logic clock = 1'b0;
  logic nreset;
  int   total = 0;
  int   bad   = 0;

  fp_addsub_iter_if #(.EXP_W(DEF_EXP_W), .MAN_W(DEF_MAN_W)) bus ();

  fp_addsub_iter #(.EXP_W(DEF_EXP_W), .MAN_W(DEF_MAN_W)) dut (
    .clock (clock),
    .nreset(nreset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    @(negedge clock);
    bus.a        = a;
    bus.b        = b;
    bus.sub      = s;
    bus.in_valid = 1'b1;
    @(posedge clock);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic s, input logic [W-1:0] exp_sum, input int exp_lat,
                        input logic exp_ovf, input logic exp_unf);
    int   lat;
    logic busy_rdy;
    @(negedge clock);
    chk({tag, ":idle_rdy"}, 32'(bus.in_ready), 32'd1);
    start_op(a, b, s);
    lat      = 0;
    busy_rdy = 1'b0;
    while (!bus.out_valid && lat < 64) begin
      busy_rdy = busy_rdy | bus.in_ready;
      @(posedge clock);
      #1;
      lat++;
    end
    chk({tag, ":lat"}, 32'(lat), 32'(exp_lat));
    chk({tag, ":sum"}, 32'(bus.sum), 32'(exp_sum));
    chk({tag, ":ovf"}, 32'(bus.ovf), 32'(exp_ovf));
    chk({tag, ":unf"}, 32'(bus.unf), 32'(exp_unf));
    chk({tag, ":busy_rdy"}, 32'(busy_rdy | bus.in_ready), 32'd0);
    @(negedge clock);
    bus.out_ready = 1'b1;
    @(posedge clock);
    #1;
    bus.out_ready = 1'b0;
    chk({tag, ":drain_vld"}, 32'(bus.out_valid), 32'd0);
  endtask

  initial begin
    int lat;
    nreset        = 1'b0;
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.sub       = 1'b0;
    bus.out_ready = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_rdy", 32'(bus.in_ready), 32'd1);
    chk("rst_vld", 32'(bus.out_valid), 32'd0);
    chk("rst_sum", 32'(bus.sum), 32'd0);
    chk("rst_ovf", 32'(bus.ovf), 32'd0);
    chk("rst_unf", 32'(bus.unf), 32'd0);
    @(negedge clock);
    nreset = 1'b1;

    run_op("add_1_2",    ONE,      16'h4000, 1'b0, 16'h4040, 5,  1'b0, 1'b0);
    run_op("cancel",     ONE,      ONE,      1'b1, 16'h0000, 2,  1'b0, 1'b0);
    run_op("sub_2_1",    16'h4000, ONE,      1'b1, ONE,      6,  1'b0, 1'b0);
    run_op("sub_1_2",    ONE,      16'h4000, 1'b1, 16'hBF80, 6,  1'b0, 1'b0);
    run_op("tie_even",   ONE,      16'h3B80, 1'b0, ONE,      12, 1'b0, 1'b0);
    run_op("tie_up",     16'h3F81, 16'h3B80, 1'b0, 16'h3F82, 12, 1'b0, 1'b0);
    run_op("clamp",      ONE,      16'h3000, 1'b0, ONE,      14, 1'b0, 1'b0);
    run_op("inf_ninf",   PINF,     16'hFF80, 1'b0, 16'h7FC0, 1,  1'b0, 1'b0);
    run_op("inf_one",    PINF,     ONE,      1'b0, PINF,     1,  1'b0, 1'b0);
    run_op("zero_b",     16'h0000, 16'hC040, 1'b0, 16'hC040, 1,  1'b0, 1'b0);
    run_op("overflow",   16'h7F7F, 16'h7F7F, 1'b0, PINF,     3,  1'b1, 1'b0);
    run_op("underflow",  16'h0081, 16'h0080, 1'b1, 16'h0000, 3,  1'b0, 1'b1);

    // Backpressure: result must hold while the consumer stalls.
    start_op(ONE, 16'h4000, 1'b0);
    lat = 0;
    while (!bus.out_valid && lat < 64) begin
      @(posedge clock);
      #1;
      lat++;
    end
    chk("bp_lat", 32'(lat), 32'd5);
    repeat (10) begin
      @(negedge clock);
      chk("bp_sum", 32'(bus.sum), 32'h4040);
      chk("bp_vld", 32'(bus.out_valid), 32'd1);
      chk("bp_rdy", 32'(bus.in_ready), 32'd0);
    end
    @(negedge clock);
    bus.out_ready = 1'b1;
    @(posedge clock);
    #1;
    bus.out_ready = 1'b0;
    chk("bp_rel_rdy", 32'(bus.in_ready), 32'd1);
    chk("bp_rel_vld", 32'(bus.out_valid), 32'd0);

    // Reset while the long clamped alignment is in progress.
    start_op(ONE, 16'h3000, 1'b0);
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("mid_rdy", 32'(bus.in_ready), 32'd0);
    nreset = 1'b0;
    @(posedge clock);
    #1;
    chk("mid_rst_vld", 32'(bus.out_valid), 32'd0);
    chk("mid_rst_sum", 32'(bus.sum), 32'd0);
    chk("mid_rst_rdy", 32'(bus.in_ready), 32'd1);
    @(negedge clock);
    nreset = 1'b1;

    run_op("post_rst", ONE, 16'h4000, 1'b0, 16'h4040, 5, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
